// File: rtl/esc_quad_pwm.sv
// esc_quad_pwm: four-channel ESC pulse generator.
// One shared frame counter drives all four PWM lines. Pulse widths are latched
// at the frame boundary; an arming sequence sends minimum-throttle frames
// before live speeds are passed through.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | motors off, all PWM low, waiting for arm at a frame boundary
// S_ARMING | ARM_PERIODS frames of BASE-width (zero-throttle) pulses
// S_RUN    | live speeds latched each frame, armed high

module esc_quad_pwm #(
  parameter int PERIOD      = 125000,
  parameter int BASE        = 6250,
  parameter int ARM_PERIODS = 200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        arm,
  input  logic [10:0] frnt_spd,
  input  logic [10:0] bck_spd,
  input  logic [10:0] lft_spd,
  input  logic [10:0] rght_spd,
  output logic        frnt_pwm,
  output logic        bck_pwm,
  output logic        lft_pwm,
  output logic        rght_pwm,
  output logic        armed,
  output logic        frame
);

  localparam int CW = $clog2(PERIOD);
  localparam int AW = (ARM_PERIODS < 1) ? 1 : $clog2(ARM_PERIODS + 1);
  localparam int WW = 14;
  // common width for comparing the frame counter against a pulse width
  localparam int MW = (CW > WW) ? CW : WW;

  localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);
  localparam logic [WW-1:0] BASE_W   = WW'(BASE);
  localparam logic [AW-1:0] ARM_LAST = AW'(ARM_PERIODS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMING = 2'd1,
    S_RUN    = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   arm_cnt_q, arm_cnt_d;
  logic [WW-1:0]   width_q [4];
  logic [WW-1:0]   width_d [4];
  logic [3:0]      pwm_q, pwm_d;
  logic            armed_q, armed_d;
  logic            frame_q, frame_d;
  logic [10:0]     spd [4];
  logic            boundary;

  // channel order: 0 front, 1 back, 2 left, 3 right
  assign spd[0] = frnt_spd;
  assign spd[1] = bck_spd;
  assign spd[2] = lft_spd;
  assign spd[3] = rght_spd;

  // frame counter: 0..PERIOD-1, boundary is the wrap edge
  always_comb begin
    boundary = (cnt_q == CNT_LAST);
    cnt_d    = boundary ? '0 : cnt_q + CW'(1);
  end

  // state and arm-frame counter next-state; arm=0 wins over everything
  always_comb begin
    state_d   = state_q;
    arm_cnt_d = arm_cnt_q;
    if (!arm) begin
      state_d   = S_IDLE;
      arm_cnt_d = '0;
    end else if (boundary) begin
      case (state_q)
        S_IDLE: begin
          state_d   = S_ARMING;
          arm_cnt_d = '0;
        end
        S_ARMING: begin
          arm_cnt_d = arm_cnt_q + AW'(1);
          if (arm_cnt_q == ARM_LAST) begin
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          state_d = S_RUN;
        end
        default: begin
          state_d   = S_IDLE;
          arm_cnt_d = '0;
        end
      endcase
    end
  end

  // width latch at the boundary and PWM level from next counter vs next width;
  // using the next-state values gives zero latency from the boundary edge
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      width_d[i] = width_q[i];
      if (boundary) begin
        if (state_d == S_ARMING) begin
          width_d[i] = BASE_W;
        end else begin
          width_d[i] = BASE_W + ({3'b000, spd[i]} * 14'd3);
        end
      end
      pwm_d[i] = (state_d != S_IDLE) && (MW'(cnt_d) < MW'(width_d[i]));
    end
    armed_d = (state_d == S_RUN);
    frame_d = boundary;
  end

  // all state and registered outputs; async reset clears everything mid-pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      arm_cnt_q <= '0;
      for (int i = 0; i < 4; i++) begin
        width_q[i] <= '0;
      end
      pwm_q     <= '0;
      armed_q   <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      arm_cnt_q <= arm_cnt_d;
      for (int i = 0; i < 4; i++) begin
        width_q[i] <= width_d[i];
      end
      pwm_q     <= pwm_d;
      armed_q   <= armed_d;
      frame_q   <= frame_d;
    end
  end

  assign frnt_pwm = pwm_q[0];
  assign bck_pwm  = pwm_q[1];
  assign lft_pwm  = pwm_q[2];
  assign rght_pwm = pwm_q[3];
  assign armed    = armed_q;
  assign frame    = frame_q;

endmodule
